// File: rtl/armleocpu_prefetch.sv
// Purpose: instruction prefetch unit; fetches via the cache port into a DEPTH-entry buffer feeding decode.
// Latency: EXECUTE is presented combinationally; data is visible at f2d one cycle after c_done.
// Backpressure: fetch stalls when the buffer plus the in-flight request would overflow; d2f_ready pops the head.
module armleocpu_prefetch #(
    parameter int DEPTH                   = 4,
    parameter int DEBUG_CMD_WIDTH         = 4,
    parameter int F2E_TYPE_WIDTH          = 2,
    parameter int ARMLEOCPU_D2F_CMD_WIDTH = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [31:0]                        reset_vector,
    output logic [3:0]                         c_cmd,
    output logic [31:0]                        c_address,
    input  logic                               c_done,
    input  logic [3:0]                         c_response,
    input  logic [31:0]                        c_load_data,
    input  logic                               interrupt_pending,
    input  logic                               dbg_mode,
    input  logic                               dbg_cmd_valid,
    input  logic [DEBUG_CMD_WIDTH-1:0]         dbg_cmd,
    input  logic [31:0]                        dbg_arg0,
    output logic                               dbg_cmd_ready,
    output logic                               dbg_pipeline_busy,
    output logic                               f2d_valid,
    output logic [F2E_TYPE_WIDTH-1:0]          f2d_type,
    output logic [31:0]                        f2d_instr,
    output logic [31:0]                        f2d_pc,
    output logic [3:0]                         f2d_resp,
    input  logic                               d2f_ready,
    input  logic [ARMLEOCPU_D2F_CMD_WIDTH-1:0] d2f_cmd,
    input  logic [31:0]                        d2f_branchtarget
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [3:0] CACHE_CMD_NONE         = 4'd0;
    localparam logic [3:0] CACHE_CMD_EXECUTE      = 4'd1;
    localparam logic [3:0] CACHE_CMD_FLUSH_ALL    = 4'd4;
    localparam logic [3:0] CACHE_RESPONSE_SUCCESS = 4'd0;
    localparam logic [F2E_TYPE_WIDTH-1:0] F2E_TYPE_INSTR             = F2E_TYPE_WIDTH'(0);
    localparam logic [F2E_TYPE_WIDTH-1:0] F2E_TYPE_INTERRUPT_PENDING = F2E_TYPE_WIDTH'(1);
    localparam logic [ARMLEOCPU_D2F_CMD_WIDTH-1:0] D2F_CMD_START_BRANCH = ARMLEOCPU_D2F_CMD_WIDTH'(1);
    localparam logic [ARMLEOCPU_D2F_CMD_WIDTH-1:0] D2F_CMD_FLUSH        = ARMLEOCPU_D2F_CMD_WIDTH'(2);
    localparam logic [DEBUG_CMD_WIDTH-1:0] DEBUG_CMD_JUMP = DEBUG_CMD_WIDTH'(1);

    // Which cache request, if any, is in flight.
    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_FLUSH} state_t;

    state_t        state_q, state_d;
    logic [31:0]   npc_q, npc_d, req_addr_q, req_addr_d;
    logic          halt_q, halt_d, discard_q, discard_d;
    logic          start_q, start_d, flush_pend_q, flush_pend_d;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d, count_after;

    logic [31:0]   fifo_instr [DEPTH];
    logic [31:0]   fifo_pc    [DEPTH];
    logic [3:0]    fifo_resp  [DEPTH];

    logic          dbg_ack, jump, branch, flush, redirect, done, idle_now;
    logic          push, pop, halt_eff, fetch_ok, issue_exec, issue_flush;
    logic [31:0]   npc_eff;

    // Command decode, issue decision, cache port drive and next-state for every register.
    always_comb begin
        dbg_ack     = rst_n && dbg_mode && dbg_cmd_valid && (state_q == ST_IDLE);
        jump        = dbg_ack && (dbg_cmd == DEBUG_CMD_JUMP);
        branch      = rst_n && d2f_ready && !jump && (d2f_cmd == D2F_CMD_START_BRANCH);
        flush       = rst_n && d2f_ready && !jump && (d2f_cmd == D2F_CMD_FLUSH);
        redirect    = jump || branch || flush;
        done        = (state_q != ST_IDLE) && c_done;
        idle_now    = rst_n && ((state_q == ST_IDLE) || done);
        // A redirect in the completion cycle drops the returning data too.
        push        = (state_q == ST_EXEC) && c_done && !discard_q && !redirect;
        pop         = rst_n && d2f_ready && !interrupt_pending && (count_q != '0) && !redirect;

        npc_eff = npc_q;
        if (jump)
            npc_eff = dbg_arg0;
        else if (branch || flush)
            npc_eff = d2f_branchtarget;
        else if (start_q)
            npc_eff = reset_vector;

        // An error completing this cycle must already block the back-to-back issue.
        halt_eff    = !redirect && (halt_q || (push && (c_response != CACHE_RESPONSE_SUCCESS)));
        count_after = redirect ? '0 : (count_q + CW'(push) - CW'(pop));
        // Room is judged after this edge's push/pop so the new request always has a slot.
        fetch_ok    = !halt_eff && !dbg_mode && !interrupt_pending && (count_after < CW'(DEPTH));
        issue_flush = idle_now && (flush || flush_pend_q);
        issue_exec  = idle_now && !issue_flush && fetch_ok;

        c_cmd     = CACHE_CMD_NONE;
        c_address = req_addr_q;
        if (issue_flush) begin
            c_cmd     = CACHE_CMD_FLUSH_ALL;
            c_address = npc_eff;
        end else if (issue_exec) begin
            c_cmd     = CACHE_CMD_EXECUTE;
            c_address = npc_eff;
        end else if (rst_n && (state_q != ST_IDLE) && !c_done) begin
            c_cmd = (state_q == ST_EXEC) ? CACHE_CMD_EXECUTE : CACHE_CMD_FLUSH_ALL;
        end

        state_d = state_q;
        if (issue_exec)
            state_d = ST_EXEC;
        else if (issue_flush)
            state_d = ST_FLUSH;
        else if (done)
            state_d = ST_IDLE;

        req_addr_d = (issue_exec || issue_flush) ? npc_eff : req_addr_q;
        npc_d      = issue_exec ? (npc_eff + 32'd4) : npc_eff;
        start_d    = start_q && !issue_exec && !redirect;
        halt_d     = halt_eff;

        discard_d = discard_q;
        if (issue_exec || issue_flush || done)
            discard_d = 1'b0;
        else if (redirect && (state_q == ST_EXEC))
            discard_d = 1'b1;

        // A flush arriving during FLUSH_ALL only retargets; one during EXECUTE waits for it.
        flush_pend_d = flush_pend_q;
        if (issue_flush)
            flush_pend_d = 1'b0;
        else if (flush && (state_q == ST_EXEC))
            flush_pend_d = 1'b1;

        count_d = count_after;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (redirect) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push)
                wptr_d = wptr_q + PW'(1);
            if (pop)
                rptr_d = rptr_q + PW'(1);
        end
    end

    assign f2d_valid         = rst_n && (interrupt_pending || (count_q != '0));
    assign f2d_type          = interrupt_pending ? F2E_TYPE_INTERRUPT_PENDING : F2E_TYPE_INSTR;
    assign f2d_pc            = (interrupt_pending && (count_q == '0)) ? npc_q : fifo_pc[rptr_q];
    assign f2d_instr         = fifo_instr[rptr_q];
    assign f2d_resp          = fifo_resp[rptr_q];
    assign dbg_cmd_ready     = dbg_ack;
    assign dbg_pipeline_busy = (state_q != ST_IDLE);

    // Control state; reset abandons any in-flight request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            npc_q        <= '0;
            req_addr_q   <= '0;
            halt_q       <= 1'b0;
            discard_q    <= 1'b0;
            start_q      <= 1'b1;
            flush_pend_q <= 1'b0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            npc_q        <= npc_d;
            req_addr_q   <= req_addr_d;
            halt_q       <= halt_d;
            discard_q    <= discard_d;
            start_q      <= start_d;
            flush_pend_q <= flush_pend_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
        end
    end

    // Buffer storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wptr_q] <= c_load_data;
            fifo_pc[wptr_q]    <= req_addr_q;
            fifo_resp[wptr_q]  <= c_response;
        end
    end
endmodule

// File: doc/armleocpu_prefetch.md
ARMLEOCPU_PREFETCH -- requirements
Module: armleocpu_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the instruction buffer entry count; legal values 2, 4, 8, 16.
REQ-002 clk  in  1  sole clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 reset_vector  in  32  first fetch address; stable from reset assertion until the first EXECUTE is issued.
REQ-005 c_cmd  out  4  cache command: CACHE_CMD_NONE / EXECUTE / FLUSH_ALL only.
REQ-006 c_address  out  32  fetch address.
REQ-007 c_done  in  1  cache request completion.
REQ-008 c_response  in  4  completion status; CACHE_RESPONSE_SUCCESS or error code.
REQ-009 c_load_data  in  32  fetched instruction, valid with c_done.
REQ-010 interrupt_pending  in  1  interrupt request.
REQ-011 dbg_mode, dbg_cmd_valid  in  1 each; dbg_cmd  in  DEBUG_CMD_WIDTH; dbg_arg0  in  32.
REQ-012 dbg_cmd_ready, dbg_pipeline_busy  out  1 each.
REQ-013 f2d_valid  out  1; f2d_type  out  F2E_TYPE_WIDTH; f2d_instr  out  32; f2d_pc  out  32; f2d_resp  out  4 (cache status of entry).
REQ-014 d2f_ready  in  1; d2f_cmd  in  ARMLEOCPU_D2F_CMD_WIDTH; d2f_branchtarget  in  32.

Function
REQ-015 Buffer SHALL be a DEPTH-entry FIFO of {instr, pc, resp}; occupancy counter 0..DEPTH; pointers wrap modulo DEPTH.
REQ-016 Next-fetch address npc SHALL increment by 4 per issued EXECUTE, wrapping modulo 2^32; targets used unaltered (no alignment).
REQ-017 New EXECUTE SHALL issue only when occupancy + (1 if request in flight and not completing) < DEPTH, no halt, dbg_mode=0, interrupt_pending=0.
REQ-018 While a request is outstanding and c_done=0, c_cmd and c_address SHALL hold unchanged.
REQ-019 c_cmd/c_address are combinational; next request MAY be presented in the same cycle c_done=1; c_cmd SHALL be NONE whenever no request is outstanding or allowed.
REQ-020 On c_done of EXECUTE (not discarded), entry SHALL be pushed same edge; pop and push in one cycle leave occupancy unchanged.
REQ-021 Response != SUCCESS: entry pushed with f2d_resp set; halt SHALL be set, stopping further fetch until branch, flush or debug jump.
REQ-022 f2d_valid = occupancy>0, f2d_type = F2E_TYPE_INSTR, fields from head; pop when f2d_valid && d2f_ready.
REQ-023 interrupt_pending=1 overrides: f2d_valid=1, f2d_type=F2E_TYPE_INTERRUPT_PENDING, f2d_pc = head pc if non-empty else npc; no pop.
REQ-024 d2f_cmd SHALL be acted on only when d2f_ready=1.
REQ-025 START_BRANCH: FIFO cleared, halt cleared, npc=d2f_branchtarget; outstanding request marked discard (data dropped on c_done); EXECUTE at target issued same cycle if idle, else in the c_done cycle.
REQ-026 FLUSH: FIFO cleared, halt cleared, outstanding request discarded; FLUSH_ALL issued when idle; on its c_done, fetch resumes at d2f_branchtarget captured with FLUSH.
REQ-027 Branch or flush during pending FLUSH_ALL: FLUSH_ALL completes; latest target wins.
REQ-028 dbg_pipeline_busy = request outstanding; dbg_cmd_ready pulses only when dbg_mode=1, dbg_cmd_valid=1, no request outstanding.
REQ-029 DEBUG_CMD_JUMP accepted: FIFO cleared, halt cleared, npc=dbg_arg0; other dbg_cmd acked with no effect; same-cycle JUMP beats d2f command.

Reset
REQ-030 rst_n low: c_cmd=NONE, f2d_valid=0, dbg_cmd_ready=0, dbg_pipeline_busy=0, FIFO empty, halt=0, discard=0, start flag set.
REQ-031 First cycle after release with start flag: EXECUTE at reset_vector, npc=reset_vector+4, start cleared.
REQ-032 Reset mid-request SHALL abandon it; no entry pushed from pre-reset request.

Verification
REQ-033 reset_vector=0x1000, c_done 1 cycle after each cmd, d2f_ready=1 -> f2d_pc 0x1000,0x1004,0x1008 consecutive, f2d_resp=SUCCESS.
REQ-034 DEPTH=4, d2f_ready=0 -> exactly 4 pushes, c_cmd=NONE afterward; d2f_ready=1 -> fetch resumes at 0x1010.
REQ-035 START_BRANCH target 0x2000 while fetch of 0x1008 outstanding -> 0x1008 data dropped, FIFO empty, next EXECUTE at 0x2000.
REQ-036 c_response error at 0x1004 -> entry with error presented, no EXECUTE until FLUSH target 0x3000 -> FLUSH_ALL then EXECUTE 0x3000.
REQ-037 interrupt_pending=1 with empty FIFO, npc=0x100C -> f2d_type INTERRUPT_PENDING, f2d_pc=0x100C, c_cmd=NONE.
REQ-038 dbg_mode=1, JUMP dbg_arg0=0x4000 -> dbg_cmd_ready after outstanding done; dbg_mode=0 -> EXECUTE at 0x4000.
